note_select: RTL and testbench

Keyboard-side producer for the physics frequency interface. Decodes PS/2 set-2 scan-code bytes into up to two held note slots (frequency ids 0–24). Presents `freq_id1`/`freq_id2` together with a `new_f` pulse that is exactly one frame long, aligned to `vsync` rising edges. Sits between the PS/2 byte receiver and the physics block; `new_f` drives the physics `new_f_in`.

---
 rtl/note_select.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_note_select.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_select.sv
`default_nettype none
// ============================================================================
//  Module      : note_select
//  Description : Keyboard-side producer for the physics frequency interface.
//                Decodes PS/2 set-2 scan-code bytes into up to two held note
//                slots (frequency ids 0..24) and hands the pair to physics
//                with a new_f pulse exactly one frame long, aligned to vsync
//                rising edges.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FRAME_MIN   minimum whole frames between the end of one new_f pulse and
//                the start of the next (1..15)
//  Ports
//    clock       pixel clock, sole clock domain
//    reset       synchronous, active-high
//    vsync       frame sync; rising edge is the active edge
//    scan_code   PS/2 byte from the receiver
//    scan_valid  one-cycle strobe qualifying scan_code
//    curr_w0     physics bank-select flag (throttling only)
//    freq_id1    first note id, stable while new_f is high
//    freq_id2    second note id, 5'b11111 when only one key is held
//    new_f       one-frame pulse announcing a new pair
//    busy        issued pair not yet adopted by physics
//  Build option
//    NOTE_THROTTLE_EN  when defined, a new pair is only issued after physics
//                      has swapped banks (curr_w0 differs from its value at
//                      the previous issue)
// ============================================================================
module note_select #(
   parameter int FRAME_MIN = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vsync,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       curr_w0,
   output logic [4:0] freq_id1,
   output logic [4:0] freq_id2,
   output logic       new_f,
   output logic       busy
);

   localparam logic [4:0] SLOT_EMPTY = 5'b11111;
   localparam logic [4:0] FREQ1_RST  = 5'd12;
   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [3:0] GAP_LOAD   = 4'(FRAME_MIN - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // ------------------------------------------------------------------------
   // Scan code to note id. Unmapped codes return SLOT_EMPTY so that a single
   // compare both rejects them and can never alias a real held note.
   // ------------------------------------------------------------------------
   function automatic logic [4:0] key_to_id(input logic [7:0] code);
      logic [4:0] id;
      case (code)
         8'h1A:   id = 5'd0;
         8'h1B:   id = 5'd1;
         8'h22:   id = 5'd2;
         8'h23:   id = 5'd3;
         8'h21:   id = 5'd4;
         8'h2A:   id = 5'd5;
         8'h34:   id = 5'd6;
         8'h32:   id = 5'd7;
         8'h33:   id = 5'd8;
         8'h31:   id = 5'd9;
         8'h3B:   id = 5'd10;
         8'h3A:   id = 5'd11;
         8'h41:   id = 5'd12;
         8'h15:   id = 5'd13;
         8'h1E:   id = 5'd14;
         8'h1D:   id = 5'd15;
         8'h26:   id = 5'd16;
         8'h24:   id = 5'd17;
         8'h2D:   id = 5'd18;
         8'h2E:   id = 5'd19;
         8'h2C:   id = 5'd20;
         8'h36:   id = 5'd21;
         8'h35:   id = 5'd22;
         8'h3D:   id = 5'd23;
         8'h3C:   id = 5'd24;
         default: id = SLOT_EMPTY;
      endcase
      return id;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic       brk_q,     brk_d;
   logic       ext_q,     ext_d;
   logic [4:0] slot_a_q,  slot_a_d;
   logic [4:0] slot_b_q,  slot_b_d;
   logic       pending_q, pending_d;
   logic       vsync_d_q;
   logic [1:0] state_q,   state_d;
   logic [3:0] gap_q,     gap_d;
   logic [4:0] freq1_q,   freq1_d;
   logic [4:0] freq2_q,   freq2_d;
   logic       new_f_q,   new_f_d;
   logic       busy_q,    busy_d;

   // ------------------------------------------------------------------------
   // Byte decoder: prefix bytes only arm flags; the following key byte
   // consumes them. Extended keys are swallowed entirely.
   // ------------------------------------------------------------------------
   logic       key_evt;
   logic       key_make;
   logic [4:0] key_id;
   logic       key_hit;

   always_comb begin
      brk_d    = brk_q;
      ext_d    = ext_q;
      key_evt  = 1'b0;
      key_make = 1'b0;
      if (scan_valid) begin
         if (scan_code == CODE_BREAK) begin
            brk_d = 1'b1;
         end else if (scan_code == CODE_EXT) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (!ext_q) begin
               key_evt  = 1'b1;
               key_make = ~brk_q;
            end
         end
      end
   end

   assign key_id  = key_to_id(scan_code);
   assign key_hit = key_evt && (key_id != SLOT_EMPTY);

   // ------------------------------------------------------------------------
   // Slot update. Slot A is always filled before B, and a release of A pulls
   // B forward, so "A empty" implies "B empty".
   // ------------------------------------------------------------------------
   logic slot_chg;

   always_comb begin
      slot_a_d = slot_a_q;
      slot_b_d = slot_b_q;
      if (key_hit) begin
         if (key_make) begin
            // A make of an already-held key is typematic repeat.
            if ((key_id != slot_a_q) && (key_id != slot_b_q)) begin
               if (slot_a_q == SLOT_EMPTY) begin
                  slot_a_d = key_id;
               end else begin
                  // Free B or newest-replaces-B: both land in B.
                  slot_b_d = key_id;
               end
            end
         end else begin
            if (key_id == slot_a_q) begin
               slot_a_d = slot_b_q;
               slot_b_d = SLOT_EMPTY;
            end else if (key_id == slot_b_q) begin
               slot_b_d = SLOT_EMPTY;
            end
         end
      end
   end

   assign slot_chg = (slot_a_d != slot_a_q) || (slot_b_d != slot_b_q);

   // ------------------------------------------------------------------------
   // Frame-synchronous issue FSM
   // ------------------------------------------------------------------------
   logic vrise;
   logic issue;
   logic exit_ok;

   assign vrise = vsync & ~vsync_d_q;
   assign issue = (state_q == ST_IDLE) && vrise && pending_q && (gap_q == 4'd0);

`ifdef NOTE_THROTTLE_EN
   // Bank flag seen at issue time; a difference means physics adopted the pair.
   logic w0_snap_q, w0_snap_d;

   assign exit_ok = (curr_w0 != w0_snap_q);

   always_comb begin
      w0_snap_d = w0_snap_q;
      if (issue) begin
         w0_snap_d = curr_w0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w0_snap_q <= 1'b0;
      end else begin
         w0_snap_q <= w0_snap_d;
      end
   end
`else
   logic unused_curr_w0;

   assign exit_ok        = 1'b1;
   assign unused_curr_w0 = curr_w0;
`endif

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      freq1_d = freq1_q;
      freq2_d = freq2_q;
      new_f_d = new_f_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            // Latch from the registered slots, so a key event in this same
            // cycle is not part of this pair.
            if (issue) begin
               freq1_d = slot_a_q;
               freq2_d = slot_b_q;
               new_f_d = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (vrise) begin
               new_f_d = 1'b0;
               gap_d   = GAP_LOAD;
               state_d = ST_WAIT;
`ifndef NOTE_THROTTLE_EN
               busy_d  = 1'b0;
`endif
            end
         end
         ST_WAIT: begin
            if (vrise && (gap_q != 4'd0)) begin
               gap_d = gap_q - 4'd1;
            end
            // Exit is judged on the registered gap, so the vrise that takes
            // gap to zero can never also issue; IDLE sees the next one.
            if ((gap_q == 4'd0) && exit_ok) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            new_f_d = 1'b0;
            busy_d  = 1'b0;
            gap_d   = 4'd0;
         end
      endcase
   end

   // Setting wins over the issue clear so a coincident key event is kept.
   always_comb begin
      pending_d = pending_q;
      if (issue) begin
         pending_d = 1'b0;
      end
      if (slot_chg && (slot_a_d != SLOT_EMPTY)) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         slot_a_q  <= SLOT_EMPTY;
         slot_b_q  <= SLOT_EMPTY;
         pending_q <= 1'b0;
         vsync_d_q <= 1'b0;
         state_q   <= ST_IDLE;
         gap_q     <= 4'd0;
         freq1_q   <= FREQ1_RST;
         freq2_q   <= SLOT_EMPTY;
         new_f_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         brk_q     <= brk_d;
         ext_q     <= ext_d;
         slot_a_q  <= slot_a_d;
         slot_b_q  <= slot_b_d;
         pending_q <= pending_d;
         vsync_d_q <= vsync;
         state_q   <= state_d;
         gap_q     <= gap_d;
         freq1_q   <= freq1_d;
         freq2_q   <= freq2_d;
         new_f_q   <= new_f_d;
         busy_q    <= busy_d;
      end
   end

   assign freq_id1 = freq1_q;
   assign freq_id2 = freq2_q;
   assign new_f    = new_f_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_note_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_select
//  Description : Directed self-checking bench for note_select. Frames are
//                16 clocks long with vsync high for the first 2 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_select;

   localparam int FRAME_LEN = 16;

   logic       clock;
   logic       reset;
   logic       vsync;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       curr_w0;
   logic [4:0] freq_id1;
   logic [4:0] freq_id2;
   logic       new_f;
   logic       busy;

   int n_cmp;
   int n_bad;
   int nf_cycles;
   int nf_rises;
   logic nf_prev;
   logic phys_due;
   logic auto_phys;

   note_select #(.FRAME_MIN(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .vsync      (vsync),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .curr_w0    (curr_w0),
      .freq_id1   (freq_id1),
      .freq_id2   (freq_id2),
      .new_f      (new_f),
      .busy       (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clock);
      scan_valid = 1'b0;
   endtask

   // Runs whole frames, counting new_f cycles and rising edges. A model of
   // physics toggles curr_w0 mid-frame after each observed pulse start.
   task automatic run_frames(input int n, input bit inj, input logic [7:0] inj_code);
      for (int f = 0; f < n; f++) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clock);
            if (new_f === 1'b1) begin
               nf_cycles++;
               if (nf_prev !== 1'b1) begin
                  nf_rises++;
                  phys_due = 1'b1;
               end
            end
            nf_prev = new_f;
            if (i == 8 && auto_phys && phys_due) begin
               curr_w0  = ~curr_w0;
               phys_due = 1'b0;
            end
            vsync = (i < 2);
            if (inj && f == 0 && i == 0) begin
               scan_code  = inj_code;
               scan_valid = 1'b1;
            end else begin
               scan_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic clear_counts();
      nf_cycles = 0;
      nf_rises  = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++; if (freq_id1 !== 5'd12) begin n_bad++; $display("FAIL reset_freq1 got %0d want 12", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL reset_freq2 got %0d want 31", freq_id2); end
      n_cmp++; if (new_f !== 1'b0) begin n_bad++; $display("FAIL reset_new_f got %b want 0", new_f); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      clear_counts();
      run_frames(2, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 0) begin n_bad++; $display("FAIL idle_no_pulse got %0d want 0", nf_rises); end
   endtask

   task automatic test_single_key();
      send_byte(8'h1B);
      clear_counts();
      run_frames(1, 1'b0, 8'h00);
      n_cmp++; if (new_f !== 1'b1) begin n_bad++; $display("FAIL single_new_f got %b want 1", new_f); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
      n_cmp++; if (freq_id1 !== 5'd1) begin n_bad++; $display("FAIL single_freq1 got %0d want 1", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL single_freq2 got %0d want 31", freq_id2); end
      run_frames(2, 1'b0, 8'h00);
      n_cmp++; if (nf_cycles !== FRAME_LEN) begin n_bad++; $display("FAIL single_width got %0d want %0d", nf_cycles, FRAME_LEN); end
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL single_rises got %0d want 1", nf_rises); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", busy); end
   endtask

   task automatic test_two_keys_replace();
      // Releasing 0x1B empties A before the new chord.
      send_byte(8'hF0);
      send_byte(8'h1B);
      send_byte(8'h1A);
      send_byte(8'h15);
      send_byte(8'h24);
      clear_counts();
      run_frames(3, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL chord_rises got %0d want 1", nf_rises); end
      n_cmp++; if (freq_id1 !== 5'd0) begin n_bad++; $display("FAIL chord_freq1 got %0d want 0", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd17) begin n_bad++; $display("FAIL chord_freq2 got %0d want 17", freq_id2); end
      send_byte(8'hF0);
      send_byte(8'h1A);
      clear_counts();
      run_frames(3, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL breakA_rises got %0d want 1", nf_rises); end
      n_cmp++; if (freq_id1 !== 5'd17) begin n_bad++; $display("FAIL breakA_freq1 got %0d want 17", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL breakA_freq2 got %0d want 31", freq_id2); end
   endtask

   task automatic test_ignored_codes();
      send_byte(8'hE0);
      send_byte(8'h1A);
      send_byte(8'h5A);
      send_byte(8'h24);
      send_byte(8'hF0);
      send_byte(8'h2A);
      clear_counts();
      run_frames(3, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 0) begin n_bad++; $display("FAIL ignored_rises got %0d want 0", nf_rises); end
      n_cmp++; if (freq_id1 !== 5'd17) begin n_bad++; $display("FAIL ignored_freq1 got %0d want 17", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL ignored_freq2 got %0d want 31", freq_id2); end
   endtask

   task automatic test_simultaneous();
      send_byte(8'h1A);
      clear_counts();
      run_frames(1, 1'b1, 8'h2A);
      n_cmp++; if (freq_id1 !== 5'd17) begin n_bad++; $display("FAIL simul_old_freq1 got %0d want 17", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd0) begin n_bad++; $display("FAIL simul_old_freq2 got %0d want 0", freq_id2); end
      n_cmp++; if (new_f !== 1'b1) begin n_bad++; $display("FAIL simul_old_new_f got %b want 1", new_f); end
      clear_counts();
      run_frames(2, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL simul_next_rises got %0d want 1", nf_rises); end
      n_cmp++; if (nf_cycles !== FRAME_LEN) begin n_bad++; $display("FAIL simul_gap got %0d want %0d", nf_cycles, FRAME_LEN); end
      n_cmp++; if (freq_id1 !== 5'd17) begin n_bad++; $display("FAIL simul_new_freq1 got %0d want 17", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd5) begin n_bad++; $display("FAIL simul_new_freq2 got %0d want 5", freq_id2); end
      run_frames(1, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid_pulse();
      send_byte(8'hF0);
      send_byte(8'h2A);
      clear_counts();
      run_frames(1, 1'b0, 8'h00);
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL breakB_freq2 got %0d want 31", freq_id2); end
      n_cmp++; if (new_f !== 1'b1) begin n_bad++; $display("FAIL pre_reset_new_f got %b want 1", new_f); end
      send_byte(8'hF0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp++; if (new_f !== 1'b0) begin n_bad++; $display("FAIL midreset_new_f got %b want 0", new_f); end
      n_cmp++; if (freq_id1 !== 5'd12) begin n_bad++; $display("FAIL midreset_freq1 got %0d want 12", freq_id1); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
      reset   = 1'b0;
      nf_prev = 1'b0;
      phys_due = 1'b0;
      // The F0 before reset is lost, so 0x1A is a make.
      send_byte(8'h1A);
      clear_counts();
      run_frames(3, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL postreset_rises got %0d want 1", nf_rises); end
      n_cmp++; if (freq_id1 !== 5'd0) begin n_bad++; $display("FAIL postreset_freq1 got %0d want 0", freq_id1); end
      n_cmp++; if (freq_id2 !== 5'd31) begin n_bad++; $display("FAIL postreset_freq2 got %0d want 31", freq_id2); end
   endtask

`ifdef NOTE_THROTTLE_EN
   task automatic test_throttle();
      auto_phys = 1'b0;
      send_byte(8'h1B);
      clear_counts();
      run_frames(1, 1'b0, 8'h00);
      n_cmp++; if (freq_id2 !== 5'd1) begin n_bad++; $display("FAIL thr_first_freq2 got %0d want 1", freq_id2); end
      send_byte(8'h22);
      clear_counts();
      run_frames(10, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 0) begin n_bad++; $display("FAIL thr_hold_rises got %0d want 0", nf_rises); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL thr_hold_busy got %b want 1", busy); end
      @(negedge clock);
      curr_w0 = ~curr_w0;
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL thr_swap_busy got %b want 0", busy); end
      clear_counts();
      run_frames(1, 1'b0, 8'h00);
      n_cmp++; if (nf_rises !== 1) begin n_bad++; $display("FAIL thr_release_rises got %0d want 1", nf_rises); end
      n_cmp++; if (freq_id2 !== 5'd2) begin n_bad++; $display("FAIL thr_release_freq2 got %0d want 2", freq_id2); end
      auto_phys = 1'b1;
      phys_due  = 1'b1;
      run_frames(2, 1'b0, 8'h00);
   endtask
`endif

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      nf_cycles  = 0;
      nf_rises   = 0;
      nf_prev    = 1'b0;
      phys_due   = 1'b0;
      auto_phys  = 1'b1;
      reset      = 1'b1;
      vsync      = 1'b0;
      scan_code  = 8'h00;
      scan_valid = 1'b0;
      curr_w0    = 1'b0;
      test_reset();
      test_single_key();
      test_two_keys_replace();
      test_ignored_codes();
      test_simultaneous();
      test_reset_mid_pulse();
`ifdef NOTE_THROTTLE_EN
      test_throttle();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
